// File: rtl/execute_stage.sv
// Execute stage: 1-cycle ALU/address/branch ops; iterative 32-step shift-add MUL when EXECUTE_MUL_EN is defined.
// Backpressure: combinational stall holds upstream while a MUL is in flight; m_* carries bubbles meanwhile.
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] x_pc,
  input  logic [6:0]  x_opcode,
  input  logic [4:0]  x_dst_reg,
  input  logic [14:0] x_mem_offset,
  input  logic [14:0] x_brn_offset,
  input  logic [19:0] x_jmp_offset,
  input  logic [31:0] x_read_data_1,
  input  logic [31:0] x_read_data_2,
  input  logic        x_mem_read,
  input  logic        x_mem_write,
  input  logic        x_mem_byte,
  input  logic        x_reg_write,
  input  logic        x_mem_to_reg,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] m_alu_result,
  output logic [31:0] m_write_data,
  output logic [4:0]  m_dst_reg,
  output logic        m_mem_read,
  output logic        m_mem_write,
  output logic        m_mem_byte,
  output logic        m_reg_write,
  output logic        m_mem_to_reg,
  output logic        m_branch_taken,
  output logic [31:0] m_branch_target
);
  localparam logic [6:0] OP_ADD  = 7'h00;
  localparam logic [6:0] OP_SUB  = 7'h01;
  localparam logic [6:0] OP_MUL  = 7'h02;
  localparam logic [6:0] OP_LDB  = 7'h10;
  localparam logic [6:0] OP_LDW  = 7'h11;
  localparam logic [6:0] OP_STB  = 7'h12;
  localparam logic [6:0] OP_STW  = 7'h13;
  localparam logic [6:0] OP_BEQ  = 7'h30;
  localparam logic [6:0] OP_JUMP = 7'h31;

  logic        stall_int;
  logic        mul_done;
  logic [31:0] mul_result;

`ifdef EXECUTE_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    stall_int  = 1'b0;
    mul_done   = 1'b0;
    mul_result = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    case (state_q)
      IDLE: begin
        if (x_opcode == OP_MUL && !flush) begin
          stall_int = 1'b1;
          state_d   = BUSY;
          cnt_d     = 5'd0;
          mcand_d   = x_read_data_1;
          mplier_d  = x_read_data_2;
          acc_d     = 32'd0;
        end
      end
      BUSY: begin
        stall_int = (cnt_q != 5'd31);
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
          acc_d   = 32'd0;
        end else begin
          // Step 32 folds into the output register instead of acc_q.
          acc_d    = mul_result;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = IDLE;
            cnt_d    = 5'd0;
            mul_done = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
`else
  assign stall_int  = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_result = 32'd0;
`endif

  assign stall = reset & stall_int;

  logic [31:0] alu_d;
  logic [31:0] target_d;
  logic        taken_d;
  logic        valid_op;
  logic        bubble;

  always_comb begin
    alu_d    = 32'd0;
    taken_d  = 1'b0;
    valid_op = 1'b1;
    target_d = x_pc + {{17{x_brn_offset[14]}}, x_brn_offset};
    case (x_opcode)
      OP_ADD:  alu_d = x_read_data_1 + x_read_data_2;
      OP_SUB:  alu_d = x_read_data_1 - x_read_data_2;
      OP_LDB, OP_LDW, OP_STB, OP_STW:
               alu_d = x_read_data_1 + {{17{x_mem_offset[14]}}, x_mem_offset};
      OP_BEQ:  taken_d = (x_read_data_1 == x_read_data_2);
      OP_JUMP: begin
        taken_d  = 1'b1;
        target_d = x_pc + {{12{x_jmp_offset[19]}}, x_jmp_offset};
      end
      OP_MUL: begin
        if (mul_done) alu_d = mul_result;
        else          valid_op = 1'b0;
      end
      default: valid_op = 1'b0;
    endcase
    bubble = !valid_op || flush || stall_int;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      m_alu_result    <= 32'd0;
      m_write_data    <= 32'd0;
      m_dst_reg       <= 5'd0;
      m_mem_read      <= 1'b0;
      m_mem_write     <= 1'b0;
      m_mem_byte      <= 1'b0;
      m_reg_write     <= 1'b0;
      m_mem_to_reg    <= 1'b0;
      m_branch_taken  <= 1'b0;
      m_branch_target <= 32'd0;
    end else begin
      m_alu_result    <= alu_d;
      m_write_data    <= x_read_data_2;
      m_dst_reg       <= x_dst_reg;
      m_mem_read      <= !bubble && x_mem_read;
      m_mem_write     <= !bubble && x_mem_write;
      m_mem_byte      <= !bubble && x_mem_byte;
      m_reg_write     <= !bubble && x_reg_write;
      m_mem_to_reg    <= !bubble && x_mem_to_reg;
      m_branch_taken  <= !bubble && taken_d;
      m_branch_target <= target_d;
    end
  end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset, sampled on the rising edge of clock.
REQ-003 SHALL have inputs x_pc[31:0], x_opcode[6:0], x_dst_reg[4:0], x_mem_offset[14:0], x_brn_offset[14:0], x_jmp_offset[19:0], x_read_data_1[31:0], x_read_data_2[31:0], x_mem_read, x_mem_write, x_mem_byte, x_reg_write, x_mem_to_reg: execute-stage operands and flags from the decode/execute pipeline register.
REQ-004 SHALL have input flush, 1: discard the current instruction and insert a bubble.
REQ-005 SHALL have output stall, 1, combinational: upstream must hold all x_* inputs stable while it is high.
REQ-006 SHALL have registered outputs m_alu_result[31:0], m_write_data[31:0], m_dst_reg[4:0], m_mem_read, m_mem_write, m_mem_byte, m_reg_write, m_mem_to_reg: memory-stage payload.
REQ-007 SHALL have registered outputs m_branch_taken, 1, and m_branch_target[31:0]: redirect request to fetch.

Function
REQ-008 SHALL decode opcodes as follows: ADD=0x00, SUB=0x01, MUL=0x02, LDB=0x10, LDW=0x11, STB=0x12, STW=0x13, BEQ=0x30, JUMP=0x31. Any other opcode SHALL be a NOP.
REQ-009 ADD/SUB SHALL set m_alu_result = rd1 ± rd2, modulo 2^32, with no overflow flag.
REQ-010 Load/store SHALL set m_alu_result = rd1 + sign_ext(x_mem_offset).
REQ-011 m_write_data SHALL always be x_read_data_2.
REQ-012 BEQ SHALL set m_branch_taken = (rd1 == rd2) and m_branch_target = x_pc + sign_ext(x_brn_offset).
REQ-013 JUMP SHALL set m_branch_taken = 1 and m_branch_target = x_pc + sign_ext(x_jmp_offset).
REQ-014 All non-MUL opcodes SHALL have 1-cycle latency: inputs present before edge k appear on m_* after edge k.
REQ-015 m_dst_reg and all m_* flags SHALL be copied from the x_* inputs. A NOP SHALL force all m_* flags and m_branch_taken to 0.
REQ-016 The FSM SHALL have states IDLE and BUSY, plus a 5-bit counter cnt.
REQ-017 When IDLE and x_opcode=MUL, the block SHALL go to BUSY with cnt=0 and load multiplicand=rd1 and multiplier=rd2 into a shift-add accumulator.
REQ-018 While BUSY, each cycle SHALL perform one shift-add step and increment cnt; at cnt=31 it SHALL return to IDLE.
REQ-019 The MUL result SHALL be the low 32 bits of rd1*rd2, written to m_alu_result on the edge leaving BUSY, with x_* flags copied.
REQ-020 MUL latency SHALL be 33 cycles from acceptance to m_* valid.
REQ-021 stall SHALL equal (IDLE and x_opcode=MUL and not flush) or (BUSY and cnt!=31).
REQ-022 While stall=1, m_* SHALL carry a bubble: all flags 0, m_branch_taken 0.
REQ-023 flush=1 SHALL take priority over all opcodes: it SHALL register a bubble and, if BUSY, abort to IDLE with cnt=0; the partial product SHALL be discarded.
REQ-024 Simultaneous flush and MUL issue SHALL not enter BUSY.
REQ-025 m_branch_taken SHALL be high for exactly one cycle per taken branch or jump.

Reset
REQ-026 With reset=0 at a clock edge, the block SHALL set state=IDLE, cnt=0, accumulator=0, all m_* data outputs 0, all flags 0, and m_branch_taken=0.
REQ-027 stall SHALL be 0 during reset.
REQ-028 Reset mid-MUL SHALL abort the operation with no result emitted.

Configuration
REQ-029 With macro EXECUTE_MUL_EN defined, MUL SHALL be implemented per REQ-016 to REQ-024.
REQ-030 Without EXECUTE_MUL_EN, no FSM, counter or accumulator SHALL be synthesized; MUL SHALL be treated as a NOP; stall SHALL be tied to 0.

Verification
REQ-031 ADD with rd1=0xFFFFFFFF, rd2=2, reg_write=1 -> next cycle m_alu_result=0x00000001, m_reg_write=1.
REQ-032 LDW with rd1=0x100, mem_offset=0x7FFC (-4) -> m_alu_result=0xFC, m_mem_read=1.
REQ-033 BEQ with pc=0x40, rd1=rd2=5, brn_offset=0x7FF0 -> m_branch_taken=1 for one cycle, target=0x30; rd2=6 -> taken=0.
REQ-034 MUL with rd1=7, rd2=0xFFFFFFFF -> stall high for 32 cycles, bubbles on m_*, then m_alu_result=0xFFFFFFF9, m_reg_write=1.
REQ-035 MUL, then flush at cycle 10 -> stall drops next cycle, no MUL result emitted, next ADD completes normally.
REQ-036 Reset=0 asserted at cycle 5 of MUL -> all m_* 0, stall 0; without EXECUTE_MUL_EN, MUL -> stall never 1, m_reg_write=0.
